fpu_vector_sequencer: RTL

- Synthesizable, self-checking stimulus engine for the fpu core; the parametrised successor to the single-vector fpu bench.
- Holds DEPTH test vectors, each with operands, op, rounding mode, expected result and expected flags.
- Issues one vector per clock into the fpu and compares each result FPU_LATENCY cycles later.
- Reports pass/fail counts and the first mismatch. Used in silicon BIST and in the regression bench.

---
 rtl/fpu_seq_pkg.sv | 62 ++++++
 rtl/fpu_tag_pipe.sv | 39 +++
 rtl/fpu_vector_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_seq_pkg.sv
// Shared encodings, vector layout and compare helper for the fpu vector sequencer.
package fpu_seq_pkg;

  typedef enum logic [2:0] {
    FPU_ADD = 3'd0,
    FPU_SUB = 3'd1,
    FPU_MUL = 3'd2,
    FPU_DIV = 3'd3
  } fpu_op_e;

  typedef enum logic [1:0] {
    RM_NEAREST = 2'd0,
    RM_ZERO    = 2'd1,
    RM_PINF    = 2'd2,
    RM_MINF    = 2'd3
  } rmode_e;

  // Bit positions inside the 8-bit fpu status flag vector.
  typedef enum int {
    FLAG_ZERO        = 0,
    FLAG_DIV_BY_ZERO = 1,
    FLAG_UNDERFLOW   = 2,
    FLAG_OVERFLOW    = 3,
    FLAG_INE         = 4,
    FLAG_INF         = 5,
    FLAG_QNAN        = 6,
    FLAG_SNAN        = 7
  } flag_pos_e;

  localparam int VEC_W         = 77;
  localparam int VEC_RMODE_LSB = 75;
  localparam int VEC_OP_LSB    = 72;
  localparam int VEC_OPA_LSB   = 40;
  localparam int VEC_OPB_LSB   = 8;
  localparam int VEC_FLAGS_LSB = 0;

  typedef struct packed {
    logic [1:0]  rmode;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [7:0]  exp_flags;
  } vec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic logic vec_match(
    input logic [31:0] out_val,
    input logic [31:0] exp_out,
    input logic [7:0]  flags,
    input logic [7:0]  exp_flags,
    input logic        chk_flags
  );
    return (out_val == exp_out) && (!chk_flags || (flags == exp_flags));
  endfunction

endpackage

// File: rtl/fpu_tag_pipe.sv
// Delay line of {valid, idx} tags that tracks which vector each fpu result belongs to.
module fpu_tag_pipe
  import fpu_seq_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push_valid_i,
  input  logic [IDX_W-1:0] push_idx_i,
  output logic             pop_valid_o,
  output logic [IDX_W-1:0] pop_idx_o
);

  logic [LATENCY-1:0] valid_q;
  logic [IDX_W-1:0]   idx_q [LATENCY];

  // Shift the tags one stage per cycle; clearing drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= push_valid_i;
      idx_q[0]   <= push_idx_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign pop_valid_o = valid_q[LATENCY-1];
  assign pop_idx_o   = idx_q[LATENCY-1];

endmodule

// File: rtl/fpu_vector_sequencer.sv
// Stimulus and scoring engine for the fpu: issues stored vectors back-to-back and
// scores each result FPU_LATENCY cycles later, keeping pass/error counts and the first miss.
module fpu_vector_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FPU_LATENCY = 4,
  parameter int CHECK_FLAGS = 1,
  parameter int ERR_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_en,
  output logic                     ld_ready,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [VEC_W-1:0]         ld_vec,
  input  logic [31:0]              ld_exp,
  input  logic [$clog2(DEPTH):0]   n_vec,
  input  logic                     start,
  output logic [1:0]               fpu_rmode,
  output logic [2:0]               fpu_op,
  output logic [31:0]              opa,
  output logic [31:0]              opb,
  input  logic [31:0]              fpu_out,
  input  logic [7:0]               fpu_flags,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   pass_cnt,
  output logic [ERR_W-1:0]         err_cnt,
  output logic [$clog2(DEPTH)-1:0] first_fail_idx,
  output logic [31:0]              first_fail_out,
  output logic                     fail_seen
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  seq_state_e state_q, state_d;
  logic ld_ready_q, ld_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [AW-1:0]    issue_ptr_q, issue_ptr_d;
  logic [AW-1:0]    last_idx_q, last_idx_d;
  logic [1:0]       rmode_q, rmode_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [NW-1:0]    pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [AW-1:0]    ff_idx_q, ff_idx_d;
  logic [31:0]      ff_out_q, ff_out_d;
  logic             fail_seen_q, fail_seen_d;

  vec_t        mem_vec_q [DEPTH];
  logic [31:0] mem_exp_q [DEPTH];

  logic          start_ok_s;
  logic          push_s;
  logic          tag_valid_s;
  logic [AW-1:0] tag_idx_s;
  logic          match_s;
  logic [NW-1:0] n_clamp_s;
  vec_t          issue_vec_s;

  assign start_ok_s  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign push_s      = (state_q == ST_ISSUE);
  assign issue_vec_s = mem_vec_q[issue_ptr_q];
  assign n_clamp_s   = (n_vec > NW'(DEPTH)) ? NW'(DEPTH) : n_vec;
  assign match_s     = vec_match(fpu_out, mem_exp_q[tag_idx_s], fpu_flags,
                                 mem_vec_q[tag_idx_s].exp_flags, CHECK_FLAGS != 0);

  // Vector store; no reset so loaded vectors survive a reset, and writes are locked out while running.
  always_ff @(posedge clk) begin
    if (ld_en && ld_ready_q) begin
      mem_vec_q[ld_addr] <= vec_t'(ld_vec);
      mem_exp_q[ld_addr] <= ld_exp;
    end
  end

  fpu_tag_pipe #(
    .LATENCY (FPU_LATENCY),
    .IDX_W   (AW)
  ) u_tag_pipe (
    .clk          (clk),
    .clr_n        (rst_n),
    .push_valid_i (push_s),
    .push_idx_i   (issue_ptr_q),
    .pop_valid_o  (tag_valid_s),
    .pop_idx_o    (tag_idx_s)
  );

  // FSM state and status flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ld_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; DRAIN ends on the edge the last issued tag is scored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (n_clamp_s == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_ISSUE: begin
        if (issue_ptr_q == last_idx_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (tag_valid_s && (tag_idx_s == last_idx_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags decoded from the next state so they register alongside it.
  always_comb begin
    ld_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      ST_IDLE:  ld_ready_d = 1'b1;
      ST_ISSUE: busy_d     = 1'b1;
      ST_DRAIN: busy_d     = 1'b1;
      ST_DONE: begin
        ld_ready_d = 1'b1;
        done_d     = 1'b1;
      end
      default: ld_ready_d = 1'b0;
    endcase
  end

  // Issue pointer, fpu operand registers and scoring.
  always_comb begin
    issue_ptr_d = issue_ptr_q;
    last_idx_d  = last_idx_q;
    rmode_d     = rmode_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    pass_d      = pass_q;
    err_d       = err_q;
    ff_idx_d    = ff_idx_q;
    ff_out_d    = ff_out_q;
    fail_seen_d = fail_seen_q;

    if (start_ok_s) begin
      issue_ptr_d = '0;
      last_idx_d  = AW'(n_clamp_s - NW'(1));
      pass_d      = '0;
      err_d       = '0;
      ff_idx_d    = '0;
      ff_out_d    = '0;
      fail_seen_d = 1'b0;
    end else if (state_q == ST_ISSUE) begin
      rmode_d     = issue_vec_s.rmode;
      op_d        = issue_vec_s.op;
      opa_d       = issue_vec_s.opa;
      opb_d       = issue_vec_s.opb;
      issue_ptr_d = issue_ptr_q + AW'(1);
    end else begin
      issue_ptr_d = issue_ptr_q;
    end

    if (tag_valid_s) begin
      if (match_s) begin
        pass_d = pass_q + NW'(1);
      end else begin
        if (err_q != {ERR_W{1'b1}}) begin
          err_d = err_q + ERR_W'(1);
        end else begin
          err_d = err_q;
        end
        if (!fail_seen_q) begin
          ff_idx_d    = tag_idx_s;
          ff_out_d    = fpu_out;
          fail_seen_d = 1'b1;
        end else begin
          fail_seen_d = fail_seen_q;
        end
      end
    end else begin
      pass_d = pass_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_ptr_q <= '0;
      last_idx_q  <= '0;
      rmode_q     <= 2'd0;
      op_q        <= 3'd0;
      opa_q       <= 32'd0;
      opb_q       <= 32'd0;
      pass_q      <= '0;
      err_q       <= '0;
      ff_idx_q    <= '0;
      ff_out_q    <= 32'd0;
      fail_seen_q <= 1'b0;
    end else begin
      issue_ptr_q <= issue_ptr_d;
      last_idx_q  <= last_idx_d;
      rmode_q     <= rmode_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      ff_idx_q    <= ff_idx_d;
      ff_out_q    <= ff_out_d;
      fail_seen_q <= fail_seen_d;
    end
  end

  assign ld_ready       = ld_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fpu_rmode      = rmode_q;
  assign fpu_op         = op_q;
  assign opa            = opa_q;
  assign opb            = opb_q;
  assign pass_cnt       = pass_q;
  assign err_cnt        = err_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_out = ff_out_q;
  assign fail_seen      = fail_seen_q;

endmodule
